// File: rtl/arcade_session_ctrl.sv
// arcade_session_ctrl: menu, launch, round timer and best-score keeper
// shared by several game cores on one button set, grid and LED bank.
module arcade_session_ctrl #(
    parameter int NUM_GAMES     = 4,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ROUND_SECS    = 60,
    parameter int RST_HOLD      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               btn_pulse,
    input  logic [15:0]              sw,
    input  logic [64*NUM_GAMES-1:0]  game_grid,
    input  logic [16*NUM_GAMES-1:0]  game_led,
    input  logic [NUM_GAMES-1:0]     game_check_ok,
    input  logic [8*NUM_GAMES-1:0]   game_score,
    output logic [5*NUM_GAMES-1:0]   game_btn_pulse,
    output logic [NUM_GAMES-1:0]     game_rst,
    output logic [63:0]              grid,
    output logic [15:0]              led,
    output logic [7:0]               score,
    output logic [2:0]               state_o
);

    localparam int SELW = $clog2(NUM_GAMES);
    localparam int TW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW   = $clog2(RST_HOLD + 1);

    localparam logic [2:0] S_MENU    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_PLAY    = 3'd2;
    localparam logic [2:0] S_WIN     = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    logic [2:0]      r_state;
    logic [SELW-1:0] r_sel;
    logic [HW-1:0]   r_hold;
    logic [TW-1:0]   r_tick;
    logic [7:0]      r_sec;
    logic [7:0]      r_last;
    logic [7:0]      r_best [NUM_GAMES];

    logic                 w_play;
    logic                 w_wrap;
    logic                 w_timeout;
    logic                 w_ok;
    logic                 w_abort;
    logic [7:0]           w_score;
    logic [7:0]           w_best_cur;
    logic                 w_new_best;
    logic [NUM_GAMES-1:0] w_sel_oh;
    logic                 w_unused;

    assign w_play     = (r_state == S_PLAY);
    assign w_wrap     = (r_tick == TW'(TICKS_PER_SEC - 1));
    assign w_timeout  = w_wrap && (r_sec == 8'd1);
    assign w_ok       = game_check_ok[r_sel];
    assign w_abort    = sw[15];
    assign w_score    = game_score[r_sel*8 +: 8];
    assign w_best_cur = r_best[r_sel];
    assign w_new_best = (w_best_cur == 8'd0) || (w_score < w_best_cur);
    assign w_sel_oh   = {{(NUM_GAMES-1){1'b0}}, 1'b1} << r_sel;
    assign w_unused   = ^{sw[14:0], game_led};

    // Session FSM: menu selection, launch hold, round timer, win capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_MENU;
            r_sel   <= '0;
            r_hold  <= '0;
            r_tick  <= '0;
            r_sec   <= '0;
            r_last  <= '0;
            for (int i = 0; i < NUM_GAMES; i++) r_best[i] <= '0;
        end else begin
            case (r_state)
                S_MENU: begin
                    if (btn_pulse[4]) begin
                        r_state <= S_LAUNCH;
                        r_hold  <= HW'(RST_HOLD);
                    end else if (btn_pulse[2]) begin
                        r_sel <= (r_sel == '0) ? SELW'(NUM_GAMES - 1)
                                               : r_sel - SELW'(1);
                    end else if (btn_pulse[3]) begin
                        r_sel <= (r_sel == SELW'(NUM_GAMES - 1)) ? '0
                                               : r_sel + SELW'(1);
                    end
                end
                S_LAUNCH: begin
                    if (r_hold == HW'(1)) begin
                        r_state <= S_PLAY;
                        r_sec   <= 8'(ROUND_SECS);
                        r_tick  <= '0;
                    end else begin
                        r_hold <= r_hold - HW'(1);
                    end
                end
                S_PLAY: begin
                    r_tick <= w_wrap ? '0 : r_tick + TW'(1);
                    if (w_wrap && r_sec != 8'd0) r_sec <= r_sec - 8'd1;
                    if (w_abort) begin
                        r_state <= S_MENU;
                    end else if (w_ok) begin
                        r_state <= S_WIN;
                        r_last  <= w_score;
                        if (w_new_best) r_best[r_sel] <= w_score;
                    end else if (w_timeout) begin
                        r_state <= S_TIMEOUT;
                    end
                end
                S_WIN, S_TIMEOUT: begin
                    if (btn_pulse[4] || w_abort) r_state <= S_MENU;
                end
                default: r_state <= S_MENU;
            endcase
        end
    end

    // Display, LED and score mux driven from the registered state.
    always_comb begin
        grid  = '0;
        led   = '0;
        score = '0;
        case (r_state)
            S_MENU: begin
                grid  = {56'h0, 8'hFF} << {r_sel, 3'b000};
                led   = {15'h0, 1'b1} << r_sel;
                score = w_best_cur;
            end
            S_PLAY: begin
                grid  = game_grid[r_sel*64 +: 64];
                led   = {r_sec, game_led[r_sel*16 +: 8]};
                score = w_score;
            end
            S_WIN: begin
                grid  = '1;
                led   = {r_sec, 8'h00};
                score = r_last;
            end
            S_TIMEOUT: begin
                grid  = 64'hAA55_AA55_AA55_AA55;
                led   = {r_sec, 8'h00};
                score = r_last;
            end
            default: ;
        endcase
    end

    assign game_rst = w_play ? ~w_sel_oh : '1;
    assign state_o  = r_state;

    for (genvar g = 0; g < NUM_GAMES; g++) begin : g_fwd
        assign game_btn_pulse[g*5 +: 5] =
            (w_play && w_sel_oh[g]) ? btn_pulse : 5'b0;
    end

endmodule

// File: tb/tb_arcade_session_ctrl.sv
// tb_arcade_session_ctrl: directed plus random stimulus against a
// behavioural session model.
module tb_arcade_session_ctrl;

    localparam int N   = 4;
    localparam int TPS = 10;
    localparam int RS  = 3;
    localparam int RH  = 4;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_UP   = 5'b00001;
    localparam logic [4:0] B_L    = 5'b00100;
    localparam logic [4:0] B_R    = 5'b01000;
    localparam logic [4:0] B_SEL  = 5'b10000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       btn_pulse = '0;
    logic [15:0]      sw = '0;
    logic [64*N-1:0]  game_grid = '0;
    logic [16*N-1:0]  game_led = '0;
    logic [N-1:0]     game_check_ok = '0;
    logic [8*N-1:0]   game_score = '0;
    logic [5*N-1:0]   game_btn_pulse;
    logic [N-1:0]     game_rst;
    logic [63:0]      grid;
    logic [15:0]      led;
    logic [7:0]       score;
    logic [2:0]       state_o;

    arcade_session_ctrl #(
        .NUM_GAMES(N), .TICKS_PER_SEC(TPS),
        .ROUND_SECS(RS), .RST_HOLD(RH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse), .sw(sw),
        .game_grid(game_grid), .game_led(game_led),
        .game_check_ok(game_check_ok), .game_score(game_score),
        .game_btn_pulse(game_btn_pulse), .game_rst(game_rst),
        .grid(grid), .led(led), .score(score), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Model: mode, selection, cycles spent in launch/play, results.
    int m_st, m_sel, m_hold, m_k, m_last, m_frz;
    int m_best [N];

    task automatic model_reset();
        m_st = 0; m_sel = 0; m_hold = 0; m_k = 0;
        m_last = 0; m_frz = 0;
        for (int i = 0; i < N; i++) m_best[i] = 0;
    endtask

    task automatic check_outputs();
        logic [63:0]    eg;
        logic [15:0]    el;
        logic [7:0]     es;
        logic [N-1:0]   er;
        logic [5*N-1:0] eb;
        int sec;
        sec = RS - m_k / TPS;
        er = '1; eb = '0; eg = '0; el = '0; es = '0;
        case (m_st)
            0: begin
                eg = 64'hFF << (m_sel * 8);
                el = 16'd1 << m_sel;
                es = 8'(m_best[m_sel]);
            end
            1: ;
            2: begin
                eg = game_grid[m_sel*64 +: 64];
                el = {8'(sec), game_led[m_sel*16 +: 8]};
                es = game_score[m_sel*8 +: 8];
                er[m_sel] = 1'b0;
                eb[m_sel*5 +: 5] = btn_pulse;
            end
            3: begin
                eg = '1;
                el = {8'(m_frz), 8'h00};
                es = 8'(m_last);
            end
            default: begin
                eg = 64'hAA55_AA55_AA55_AA55;
                el = {8'(m_frz), 8'h00};
                es = 8'(m_last);
            end
        endcase
        check("state", 64'(state_o), 64'(m_st));
        check("game_rst", 64'(game_rst), 64'(er));
        check("game_btn", 64'(game_btn_pulse), 64'(eb));
        check("grid", grid, eg);
        check("led", 64'(led), 64'(el));
        check("score", 64'(score), 64'(es));
    endtask

    task automatic model_step();
        int sc;
        case (m_st)
            0: begin
                if (btn_pulse[4]) begin
                    m_st = 1; m_hold = 0;
                end else if (btn_pulse[2]) m_sel = (m_sel + N - 1) % N;
                else if (btn_pulse[3]) m_sel = (m_sel + 1) % N;
            end
            1: begin
                m_hold++;
                if (m_hold == RH) begin
                    m_st = 2; m_k = 0;
                end
            end
            2: begin
                if (sw[15]) m_st = 0;
                else if (game_check_ok[m_sel]) begin
                    sc = int'(game_score[m_sel*8 +: 8]);
                    m_st = 3; m_last = sc;
                    if (m_best[m_sel] == 0 || sc < m_best[m_sel])
                        m_best[m_sel] = sc;
                    m_frz = RS - (m_k + 1) / TPS;
                end else if (m_k == RS * TPS - 1) begin
                    m_st = 4; m_frz = 0;
                end else m_k++;
            end
            default: if (btn_pulse[4] || sw[15]) m_st = 0;
        endcase
    endtask

    task automatic do_cycle(input logic [4:0] b, input logic s,
                            input logic [N-1:0] ok,
                            input logic [8*N-1:0] sc);
        @(negedge clk);
        btn_pulse = b;
        sw = {s, 15'h0};
        game_check_ok = ok;
        game_score = sc;
        for (int g = 0; g < N; g++) begin
            game_grid[g*64 +: 64] = {$urandom, $urandom};
            game_led[g*16 +: 16] = 16'($urandom);
        end
        #1 check_outputs();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(B_NONE, 1'b0, '0, '0);
    endtask

    task automatic launch();
        do_cycle(B_SEL, 1'b0, '0, '0);
        idle(RH);
    endtask

    task automatic win_g1(input logic [7:0] s1);
        do_cycle(B_NONE, 1'b0, 4'b0010, {16'h0, s1, 8'h0});
    endtask

    initial begin
        logic [4:0] b;
        int r;
        model_reset();
        #12 check_outputs();
        check("reset_grid", grid, 64'h0000_0000_0000_00FF);
        @(negedge clk) rst_n = 1'b1;

        do_cycle(B_L, 1'b0, '0, '0);
        idle(1);
        check("menu_led_sel3", 64'(led), 64'h0008);
        do_cycle(B_R, 1'b0, '0, '0);
        do_cycle(B_R, 1'b0, '0, '0);
        launch();
        do_cycle(B_UP, 1'b0, '0, '0);
        idle(29);
        idle(1);
        check("timeout_grid", grid, 64'hAA55_AA55_AA55_AA55);
        do_cycle(B_SEL, 1'b0, '0, '0);

        launch(); idle(3); win_g1(8'd12);
        idle(1);
        check("win_score12", 64'(score), 64'd12);
        do_cycle(B_SEL, 1'b0, '0, '0);
        launch(); win_g1(8'd20); do_cycle(B_SEL, 1'b0, '0, '0);
        idle(1);
        check("best_kept12", 64'(score), 64'd12);
        launch(); win_g1(8'd9); do_cycle(B_SEL, 1'b0, '0, '0);
        launch(); idle(29); win_g1(8'd15);
        idle(1);
        check("win_at_timeout", 64'(state_o), 64'd3);
        do_cycle(B_SEL, 1'b0, '0, '0);
        idle(1);
        check("best_now9", 64'(score), 64'd9);

        launch(); idle(5);
        do_cycle(B_NONE, 1'b1, '0, '0);
        idle(1);
        launch(); idle(7);

        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;
        do_cycle(B_R, 1'b0, '0, '0);
        idle(1);

        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 15));
            b = B_NONE;
            if (r < 5) b[r] = 1'b1;
            do_cycle(b, $urandom_range(0, 99) == 0,
                     {$urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0,
                      $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0},
                     $urandom & 32'h1F1F_1F1F);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arcade_session_ctrl.md
# arcade_session_ctrl

Session controller that shares the single button set, 8x8 grid and LED bank among `NUM_GAMES` game cores (maze, etc.). It runs a menu, launches the chosen game with a clean reset, and routes buttons only to that game. It enforces a per-round time limit, detects win via the game's `check_ok`, and keeps a per-game best score. It sits between the button debouncer and the game cores on one side, and the display/LED drivers on the other.

## Interface
- `NUM_GAMES`, 4, number of attached games (2..8)
- `TICKS_PER_SEC`, 50_000_000, clk cycles per second
- `ROUND_SECS`, 60, round limit in seconds (1..255); 0 = no limit
- `RST_HOLD`, 4, cycles the launched game is held in reset (≥1)
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `btn_pulse` in 5: one-cycle debounced pulses; [0] Up, [1] Down, [2] Left, [3] Right, [4] Select
- `sw` in 16: sw[15] level = abort to menu; others unused
- `game_grid` in 64*NUM_GAMES: game g grid at [g*64 +: 64]
- `game_led` in 16*NUM_GAMES: game g LEDs at [g*16 +: 16]
- `game_check_ok` in NUM_GAMES: game g success flag
- `game_score` in 8*NUM_GAMES: game g score at [g*8 +: 8]
- `game_btn_pulse` out 5*NUM_GAMES: buttons forwarded to game g at [g*5 +: 5]
- `game_rst` out NUM_GAMES: active-high sync reset per game
- `grid` out 64: display frame
- `led` out 16: LED bank
- `score` out 8: displayed score
- `state_o` out 3: current state encoding (MENU=0, LAUNCH=1, PLAY=2, WIN=3, TIMEOUT=4)

## Operation
- States: MENU, LAUNCH, PLAY, WIN, TIMEOUT. Reset → MENU, `sel`=0, all best=0, `sec_left`=0, tick=0.
- MENU: Left decrements `sel`, Right increments, both wrapping modulo NUM_GAMES. Select → LAUNCH with hold counter = RST_HOLD. Up/Down are ignored.
- LAUNCH: counts down RST_HOLD cycles, then → PLAY. On that transition, `sec_left`←ROUND_SECS and tick←0.
- PLAY: priority order per cycle:
  - sw[15]=1 → MENU.
  - Otherwise game_check_ok[sel]=1 → WIN; capture game_score[sel] into `last`. If best[sel]==0 or `last`<best[sel], best[sel]←`last` (lower is better).
  - Otherwise timeout → TIMEOUT.
  - Win and timeout in the same cycle: WIN.
- Timer, PLAY only: tick counts 0..TICKS_PER_SEC-1 and wraps. On wrap, `sec_left` decrements. Timeout fires on the wrap where `sec_left`==1. With ROUND_SECS=0 the timer never fires.
- WIN / TIMEOUT: Select → MENU. sw[15]=1 → MENU. Other buttons are ignored.
- `game_rst[g]` = 1 unless state==PLAY and g==sel. This holds unselected games and the launched game during LAUNCH.
- `game_btn_pulse[g]` = btn_pulse when state==PLAY and g==sel, else 0. The selected game's Select is forwarded as its own position reset.
- `grid`:
  - MENU: row `sel` lit (bits [sel*8 +: 8] = 8'hFF), all else 0.
  - LAUNCH: 0.
  - PLAY: game_grid[sel].
  - WIN: 64'hFFFF_FFFF_FFFF_FFFF.
  - TIMEOUT: 64'hAA55_AA55_AA55_AA55.
- `led`:
  - MENU: one-hot `sel` in [7:0], [15:8]=0.
  - LAUNCH: 0.
  - PLAY: {`sec_left`, game_led[sel][7:0]}.
  - WIN / TIMEOUT: {`sec_left`, 8'h00}.
- `score`:
  - MENU: best[sel].
  - LAUNCH: 0.
  - PLAY: game_score[sel].
  - WIN / TIMEOUT: `last`.

## Timing
- Reset values: state MENU, `game_rst` all 1, `game_btn_pulse` 0, `grid` = 64'h0000_0000_0000_00FF, `led` = 16'h0001, `score` 0, `state_o` 0.
- All state transitions are registered and take effect the cycle after the triggering input is sampled.
- Button forwarding and output muxing are combinational from registered state and `sel`, with zero added latency.
- The Select that launches a game is not forwarded. LAUNCH lasts exactly RST_HOLD cycles. The first cycle with game_rst[sel]=0 is the first PLAY cycle.
- The game's `check_ok` is sampled only in PLAY. A stale `check_ok` during LAUNCH is ignored.
- `rst_n` assertion mid-round returns to MENU immediately (async) and clears best scores.

## Test plan
- Reset → `state_o`=0, `game_rst`=4'hF, `led`=16'h0001, `grid`=64'hFF, `score`=0.
- MENU: Left ×1 from sel=0 → sel=3, `led`=16'h0008, grid bits [31:24]=FF. Right → sel=0.
- Select on sel=1 with RST_HOLD=4 → `game_rst`=4'hF for exactly 4 cycles, then 4'hD. Up pulse in PLAY appears only on game_btn_pulse[9:5]=5'b00001.
- TICKS_PER_SEC=10, ROUND_SECS=3: no check_ok → TIMEOUT exactly 30 cycles after PLAY entry. `grid`=64'hAA55AA55AA55AA55. Select → MENU.
- Game 1 asserts check_ok with score 12 → WIN, `score`=12, best[1]=12. A replay winning with 20 leaves best 12. A replay with 9 updates best to 9. check_ok coinciding with the timeout cycle → WIN.
- sw[15]=1 during PLAY → MENU next cycle. `rst_n` low mid-PLAY → outputs return to reset values asynchronously.
